// File: rtl/cpu_init_sequencer.sv
// Sweeps BTB, BHT and register-file init ports, then releases the core via start_switch.
// Optional INIT_SP_EN: presets register x2 with SP_INIT during the register sweep.
module cpu_init_sequencer #(
  parameter int          BTB_DEPTH    = 256,
  parameter int          BHT_DEPTH    = 256,
  parameter int          REG_COUNT    = 32,
  parameter int          HOLD_CYCLES  = 2,
  parameter logic [1:0]  BHT_INIT_VAL = 2'b01,
  parameter bit          AUTO_START   = 1'b0
`ifdef INIT_SP_EN
  , parameter logic [31:0] SP_INIT    = 32'h0000_03FC
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  output logic [7:0]  btb_addr,
  output logic [39:0] btb_init,
  output logic [7:0]  bht_addr,
  output logic [1:0]  bht_init,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_init,
  output logic        rst_switch,
  output logic        start_switch,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BTB  = 3'd1;
  localparam logic [2:0] S_BHT  = 3'd2;
  localparam logic [2:0] S_REG  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [7:0] BTB_LAST = 8'(BTB_DEPTH - 1);
  localparam logic [7:0] BHT_LAST = 8'(BHT_DEPTH - 1);
  localparam logic [7:0] REG_LAST = 8'(REG_COUNT - 1);

  logic [2:0]    state_reg, state_next;
  logic [7:0]    idx_reg, idx_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic [7:0]    phase_last;
  logic [2:0]    phase_after;
  logic          sweeping_next;
  logic [31:0]   reg_value_next;

  always_comb begin
    phase_last  = BTB_LAST;
    phase_after = S_BHT;
    case (state_reg)
      S_BHT: begin
        phase_last  = BHT_LAST;
        phase_after = S_REG;
      end
      S_REG: begin
        phase_last  = REG_LAST;
        phase_after = S_DONE;
      end
      default: ;
    endcase
  end

  // go is only honoured in IDLE and DONE; during a sweep it has no effect.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    hold_next  = hold_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (go || (AUTO_START && state_reg == S_IDLE)) begin
          state_next = S_BTB;
          idx_next   = 8'd0;
          hold_next  = '0;
        end
      end
      S_BTB, S_BHT, S_REG: begin
        if (hold_reg == HOLD_LAST) begin
          hold_next = '0;
          if (idx_reg == phase_last) begin
            idx_next   = 8'd0;
            state_next = phase_after;
          end else begin
            idx_next = idx_reg + 8'd1;
          end
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = 8'd0;
        hold_next  = '0;
      end
    endcase
  end

  assign sweeping_next = (state_next == S_BTB) || (state_next == S_BHT) || (state_next == S_REG);

`ifdef INIT_SP_EN
  assign reg_value_next = (state_next == S_REG && idx_next == 8'd2) ? SP_INIT : 32'd0;
`else
  assign reg_value_next = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      idx_reg   <= 8'd0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      hold_reg  <= hold_next;
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_addr     <= 8'd0;
      btb_init     <= 40'd0;
      bht_addr     <= 8'd0;
      bht_init     <= BHT_INIT_VAL;
      reg_addr     <= 5'd0;
      reg_init     <= 32'd0;
      rst_switch   <= 1'b0;
      start_switch <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      btb_addr     <= (state_next == S_BTB) ? idx_next : 8'd0;
      btb_init     <= 40'd0;
      bht_addr     <= (state_next == S_BHT) ? idx_next : 8'd0;
      bht_init     <= BHT_INIT_VAL;
      reg_addr     <= (state_next == S_REG) ? idx_next[4:0] : 5'd0;
      reg_init     <= reg_value_next;
      rst_switch   <= sweeping_next;
      start_switch <= (state_next == S_DONE);
      busy         <= sweeping_next;
      done         <= (state_next == S_DONE);
    end
  end

endmodule
